// File: rtl/latency_probe_rx.sv
// Receive-side latency probe: one register stage on the AXI stream, plus a
// per-packet latency measurement (local time minus tx timestamp) and statistics.
module latency_probe_rx #(
   parameter int SUM_WIDTH    = 48,
   parameter int RB_ADDR_BASE = 0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic [63:0]  timer,
   input  logic [31:0]  thresh,
   input  logic [31:0]  s_axis_tdata,
   input  logic         s_axis_tlast,
   input  logic         s_axis_tvalid,
   output logic         s_axis_tready,
   input  logic [127:0] s_axis_tuser,
   output logic [31:0]  m_axis_tdata,
   output logic         m_axis_tlast,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic [127:0] m_axis_tuser,
   output logic         latency_valid,
   output logic [31:0]  latency_out,
   input  logic [7:0]   rb_addr,
   output logic [63:0]  rb_data
);

   localparam logic [63:0] RB_BAD = 64'h0BADC0DE0BADC0DE;

   logic [31:0]          data_q, data_d;
   logic                 last_q, last_d;
   logic [127:0]         user_q, user_d;
   logic                 vld_q, vld_d;
   logic                 sop_q, sop_d;
   logic [31:0]          count_q, count_d;
   logic [31:0]          min_q, min_d;
   logic [31:0]          max_q, max_d;
   logic [31:0]          over_q, over_d;
   logic [SUM_WIDTH-1:0] sum_q, sum_d;
   logic [31:0]          lat_q, lat_d;
   logic                 lat_vld_q, lat_vld_d;
   logic [63:0]          rb_q, rb_d;

   logic                 accept;
   logic                 meas;
   logic [31:0]          lat;
   logic [7:0]           rb_off;
   logic                 unused_timer_hi;

   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFFFFFF) ? v : v + 32'd1;
   endfunction

   function automatic logic [SUM_WIDTH-1:0] sat_add_sum(input logic [SUM_WIDTH-1:0] s,
                                                        input logic [31:0] l);
      logic [SUM_WIDTH:0] t;
      t = {1'b0, s} + (SUM_WIDTH+1)'(l);
      return t[SUM_WIDTH] ? '1 : t[SUM_WIDTH-1:0];
   endfunction

   assign s_axis_tready   = ~vld_q | m_axis_tready;
   assign unused_timer_hi = ^timer[63:32];

   always_comb begin
      accept = s_axis_tvalid & s_axis_tready;
      // Modulo-2^32 subtraction absorbs timer wrap between stamp and receive.
      lat    = timer[31:0] - s_axis_tuser[63:32];
      meas   = accept & sop_q & s_axis_tuser[125];

      data_d    = data_q;
      last_d    = last_q;
      user_d    = user_q;
      vld_d     = vld_q;
      sop_d     = sop_q;
      count_d   = count_q;
      min_d     = min_q;
      max_d     = max_q;
      over_d    = over_q;
      sum_d     = sum_q;
      lat_d     = lat_q;
      lat_vld_d = meas;

      if (accept) begin
         data_d = s_axis_tdata;
         last_d = s_axis_tlast;
         user_d = s_axis_tuser;
         vld_d  = 1'b1;
         sop_d  = s_axis_tlast;
      end else if (m_axis_tready) begin
         vld_d = 1'b0;
      end

      if (meas) lat_d = lat;

      // Clear takes priority over a coincident sample; latency_out still updates.
      if (clear) begin
         count_d = '0;
         min_d   = 32'hFFFFFFFF;
         max_d   = '0;
         over_d  = '0;
         sum_d   = '0;
      end else if (meas) begin
         count_d = sat_inc32(count_q);
         sum_d   = sat_add_sum(sum_q, lat);
         if (lat < min_q) min_d = lat;
         if (lat > max_q) max_d = lat;
         if (lat > thresh) over_d = sat_inc32(over_q);
      end

      rb_off = rb_addr - 8'(RB_ADDR_BASE);
      case (rb_off)
         8'd0:    rb_d = {32'h0, count_q};
         8'd1:    rb_d = {32'h0, min_q};
         8'd2:    rb_d = {32'h0, max_q};
         8'd3:    rb_d = 64'(sum_q);
         8'd4:    rb_d = {32'h0, lat_q};
         8'd5:    rb_d = {32'h0, over_q};
         default: rb_d = RB_BAD;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_q    <= '0;
         last_q    <= 1'b0;
         user_q    <= '0;
         vld_q     <= 1'b0;
         sop_q     <= 1'b1;
         count_q   <= '0;
         min_q     <= 32'hFFFFFFFF;
         max_q     <= '0;
         over_q    <= '0;
         sum_q     <= '0;
         lat_q     <= '0;
         lat_vld_q <= 1'b0;
         rb_q      <= '0;
      end else begin
         data_q    <= data_d;
         last_q    <= last_d;
         user_q    <= user_d;
         vld_q     <= vld_d;
         sop_q     <= sop_d;
         count_q   <= count_d;
         min_q     <= min_d;
         max_q     <= max_d;
         over_q    <= over_d;
         sum_q     <= sum_d;
         lat_q     <= lat_d;
         lat_vld_q <= lat_vld_d;
         rb_q      <= rb_d;
      end
   end

   assign m_axis_tdata  = data_q;
   assign m_axis_tlast  = last_q;
   assign m_axis_tuser  = user_q;
   assign m_axis_tvalid = vld_q;
   assign latency_valid = lat_vld_q;
   assign latency_out   = lat_q;
   assign rb_data       = rb_q;

endmodule

// File: tb/tb_latency_probe_rx.sv
// Randomized self-checking bench for latency_probe_rx; the reference model keeps
// the list of latency samples since the last clear and derives statistics from it.
module tb_latency_probe_rx;

   logic         clk = 1'b0;
   logic         reset;
   logic         clear;
   logic [63:0]  timer;
   logic [31:0]  thresh;
   logic [31:0]  s_axis_tdata;
   logic         s_axis_tlast;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic [127:0] s_axis_tuser;
   logic [31:0]  m_axis_tdata;
   logic         m_axis_tlast;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic [127:0] m_axis_tuser;
   logic         latency_valid;
   logic [31:0]  latency_out;
   logic [7:0]   rb_addr;
   logic [63:0]  rb_data;

   latency_probe_rx dut (
      .clk(clk), .reset(reset), .clear(clear), .timer(timer), .thresh(thresh),
      .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tuser(m_axis_tuser),
      .latency_valid(latency_valid), .latency_out(latency_out),
      .rb_addr(rb_addr), .rb_data(rb_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  d;
      logic         l;
      logic [127:0] u;
      int           c;
   } beat_t;

   localparam logic [63:0] SUM_MAX = (64'd1 << 48) - 64'd1;
   localparam logic [63:0] BAD     = 64'h0BADC0DE0BADC0DE;

   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          tr_mode = 0;
   beat_t       exp_beats[$];
   beat_t       got_beats[$];
   logic [31:0] exp_lat[$];
   logic [31:0] got_lat[$];
   logic [31:0] m_lats[$];
   bit          m_ovr[$];
   logic [31:0] m_last = 32'h0;

   always @(posedge clk) cyc++;

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk); #1;
         case (tr_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         if (m_axis_tvalid && m_axis_tready)
            got_beats.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser, cyc});
         if (latency_valid) got_lat.push_back(latency_out);
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [63:0] model_stat(int k);
      logic [31:0] mn;
      logic [31:0] mx;
      logic [31:0] ov;
      logic [63:0] s;
      mn = 32'hFFFFFFFF; mx = 32'h0; ov = 32'h0; s = 64'h0;
      foreach (m_lats[i]) begin
         if (m_lats[i] < mn) mn = m_lats[i];
         if (m_lats[i] > mx) mx = m_lats[i];
         s = s + 64'(m_lats[i]);
         if (m_ovr[i]) ov = ov + 32'd1;
      end
      if (s > SUM_MAX) s = SUM_MAX;
      case (k)
         0:       return 64'(m_lats.size());
         1:       return {32'h0, mn};
         2:       return {32'h0, mx};
         3:       return s;
         4:       return {32'h0, m_last};
         5:       return {32'h0, ov};
         default: return BAD;
      endcase
   endfunction

   task automatic model_clear();
      m_lats.delete();
      m_ovr.delete();
   endtask

   task automatic reset_queues();
      exp_beats.delete(); got_beats.delete();
      exp_lat.delete();   got_lat.delete();
   endtask

   task automatic send_beat(input logic [31:0] d, input logic l, input logic [127:0] u,
                            input logic [63:0] tmr, input logic clr, input bit is_sop);
      bit          ok;
      int          waited;
      logic [31:0] lat;
      ok = 0; waited = 0;
      s_axis_tdata = d; s_axis_tlast = l; s_axis_tuser = u; s_axis_tvalid = 1'b1;
      timer = tmr; clear = clr;
      while (!ok && waited < 100) begin
         @(negedge clk);
         if (s_axis_tready) ok = 1;
         else begin
            @(posedge clk); #1;
            waited++;
         end
      end
      if (!ok) begin
         n_total++;
         $display("FAIL accept_timeout: beat data=%h not accepted within %0d cycles", d, waited);
      end else begin
         exp_beats.push_back('{d, l, u, cyc});
         if (is_sop && u[125]) begin
            lat = tmr[31:0] - u[63:32];
            exp_lat.push_back(lat);
            m_last = lat;
            if (clr) model_clear();
            else begin
               m_lats.push_back(lat);
               m_ovr.push_back(lat > thresh);
            end
         end else if (clr) model_clear();
      end
      @(posedge clk); #1;
      clear = 1'b0;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_packet(input int n, input logic [31:0] ts, input logic ht,
                              input logic [63:0] tmr, input logic clr_on_sop);
      logic [127:0] u;
      for (int i = 0; i < n; i++) begin
         u = {$urandom, $urandom, $urandom, $urandom};
         if (i == 0) begin
            u[125]    = ht;
            u[63:32]  = ts;
         end
         send_beat($urandom, (i == n - 1), u, tmr, (i == 0) ? clr_on_sop : 1'b0, (i == 0));
      end
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      model_clear();
   endtask

   task automatic drain();
      int w;
      w = 0;
      while (got_beats.size() < exp_beats.size() && w < 400) begin
         @(posedge clk); #1;
         w++;
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic rb_read(input logic [7:0] a, output logic [63:0] v);
      rb_addr = a;
      @(posedge clk); #1;
      v = rb_data;
   endtask

   task automatic test_reset();
      logic [63:0] v;
      reset = 1'b1; clear = 1'b0; timer = '0; thresh = '0;
      s_axis_tdata = '0; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b0; s_axis_tuser = '0;
      rb_addr = 8'd0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (s_axis_tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", s_axis_tready); else n_pass++;
      n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
      n_total++; if (latency_valid !== 1'b0) $display("FAIL reset_latvalid: got %b want 0", latency_valid); else n_pass++;
      n_total++; if (latency_out !== 32'h0) $display("FAIL reset_latout: got %h want 0", latency_out); else n_pass++;
      n_total++; if (rb_data !== 64'h0) $display("FAIL reset_rbdata: got %h want 0", rb_data); else n_pass++;
      reset = 1'b0;
      @(posedge clk); #1;
      rb_read(8'd1, v);
      n_total++; if (v !== 64'hFFFFFFFF) $display("FAIL reset_min: got %h want ffffffff", v); else n_pass++;
      rb_read(8'd0, v);
      n_total++; if (v !== 64'h0) $display("FAIL reset_count: got %h want 0", v); else n_pass++;
   endtask

   task automatic test_single();
      logic [63:0] v;
      reset_queues();
      thresh = 32'd1000;
      send_packet(4, 32'd100, 1'b1, 64'd130, 1'b0);
      drain();
      n_total++; if (got_lat.size() != 1) $display("FAIL single_pulses: got %0d want 1", got_lat.size()); else n_pass++;
      n_total++; if (latency_out !== 32'd30) $display("FAIL single_lat: got %0d want 30", latency_out); else n_pass++;
      n_total++; if (got_beats.size() != 4) $display("FAIL single_nbeats: got %0d want 4", got_beats.size()); else n_pass++;
      for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
         n_total++;
         if (got_beats[i].d !== exp_beats[i].d || got_beats[i].l !== exp_beats[i].l ||
             got_beats[i].u !== exp_beats[i].u || got_beats[i].c != exp_beats[i].c + 1)
            $display("FAIL single_beat%0d: got d=%h l=%b cyc=%0d want d=%h l=%b cyc=%0d", i,
                     got_beats[i].d, got_beats[i].l, got_beats[i].c,
                     exp_beats[i].d, exp_beats[i].l, exp_beats[i].c + 1);
         else n_pass++;
      end
      for (int k = 0; k < 4; k++) begin
         rb_read(8'(k), v);
         n_total++;
         if (v !== ((k == 0) ? 64'd1 : 64'd30)) $display("FAIL single_rb%0d: got %h want %h", k, v, (k == 0) ? 64'd1 : 64'd30);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      reset_queues();
      send_packet(2, 32'hFFFFFFF0, 1'b1, 64'h12345678_00000010, 1'b0);
      drain();
      n_total++;
      if (got_lat.size() != 1 || got_lat[0] !== 32'd32)
         $display("FAIL wrap_lat: got %0d samples last=%0d want 1 sample of 32", got_lat.size(), latency_out);
      else n_pass++;
   endtask

   task automatic test_three();
      logic [63:0] v;
      logic [31:0] ts;
      int          lats[3] = '{50, 20, 80};
      logic [63:0] want[6] = '{64'd3, 64'd20, 64'd80, 64'd150, 64'd80, 64'd1};
      reset_queues();
      pulse_clear();
      thresh = 32'd60;
      for (int p = 0; p < 3; p++) begin
         ts = $urandom;
         send_packet(3, ts, 1'b1, {32'h0, ts + 32'(lats[p])}, 1'b0);
      end
      drain();
      for (int k = 0; k < 6; k++) begin
         rb_read(8'(k), v);
         n_total++;
         if (v !== want[k]) $display("FAIL three_rb%0d: got %0d want %0d", k, v, want[k]);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] v;
      reset_queues();
      pulse_clear();
      thresh = $urandom;
      tr_mode = 1;
      for (int p = 0; p < 8; p++)
         send_packet(8, $urandom, 1'b1, {$urandom, $urandom}, 1'b0);
      drain();
      tr_mode = 0;
      n_total++; if (got_beats.size() != 64) $display("FAIL bp_nbeats: got %0d want 64", got_beats.size()); else n_pass++;
      for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
         n_total++;
         if (got_beats[i].d !== exp_beats[i].d || got_beats[i].l !== exp_beats[i].l || got_beats[i].u !== exp_beats[i].u)
            $display("FAIL bp_beat%0d: got d=%h l=%b want d=%h l=%b", i,
                     got_beats[i].d, got_beats[i].l, exp_beats[i].d, exp_beats[i].l);
         else n_pass++;
      end
      n_total++; if (got_lat.size() != 8) $display("FAIL bp_pulses: got %0d want 8", got_lat.size()); else n_pass++;
      rb_read(8'd0, v);
      n_total++; if (v !== 64'd8) $display("FAIL bp_count: got %0d want 8", v); else n_pass++;
      for (int k = 1; k < 6; k++) begin
         rb_read(8'(k), v);
         n_total++;
         if (v !== model_stat(k)) $display("FAIL bp_rb%0d: got %h want %h", k, v, model_stat(k));
         else n_pass++;
      end
   endtask

   task automatic test_no_time();
      logic [63:0] v;
      reset_queues();
      send_packet(3, $urandom, 1'b0, {$urandom, $urandom}, 1'b0);
      drain();
      n_total++; if (got_lat.size() != 0) $display("FAIL notime_pulses: got %0d want 0", got_lat.size()); else n_pass++;
      n_total++; if (got_beats.size() != 3) $display("FAIL notime_nbeats: got %0d want 3", got_beats.size()); else n_pass++;
      rb_read(8'd0, v);
      n_total++; if (v !== model_stat(0)) $display("FAIL notime_count: got %0d want %0d", v, model_stat(0)); else n_pass++;
   endtask

   task automatic test_clear();
      logic [63:0] v;
      reset_queues();
      send_packet(2, 32'd500, 1'b1, 64'd540, 1'b1);
      drain();
      n_total++;
      if (got_lat.size() != 1 || latency_out !== 32'd40)
         $display("FAIL clear_lat: got %0d samples last=%0d want 1 sample of 40", got_lat.size(), latency_out);
      else n_pass++;
      rb_read(8'd0, v);
      n_total++; if (v !== 64'd0) $display("FAIL clear_count: got %0d want 0", v); else n_pass++;
      rb_read(8'd1, v);
      n_total++; if (v !== 64'hFFFFFFFF) $display("FAIL clear_min: got %h want ffffffff", v); else n_pass++;
      rb_read(8'd4, v);
      n_total++; if (v !== 64'd40) $display("FAIL clear_rblat: got %0d want 40", v); else n_pass++;
      rb_read(8'd9, v);
      n_total++; if (v !== BAD) $display("FAIL clear_badaddr: got %h want %h", v, BAD); else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] v;
      reset_queues();
      thresh = $urandom;
      for (int p = 0; p < 20; p++) begin
         tr_mode = $urandom_range(0, 1);
         send_packet($urandom_range(1, 5), $urandom, 1'($urandom), {$urandom, $urandom}, 1'b0);
      end
      tr_mode = 0;
      drain();
      n_total++;
      if (got_lat.size() != exp_lat.size()) $display("FAIL rand_pulses: got %0d want %0d", got_lat.size(), exp_lat.size());
      else n_pass++;
      for (int i = 0; i < exp_lat.size() && i < got_lat.size(); i++) begin
         n_total++;
         if (got_lat[i] !== exp_lat[i]) $display("FAIL rand_lat%0d: got %h want %h", i, got_lat[i], exp_lat[i]);
         else n_pass++;
      end
      n_total++;
      if (got_beats.size() != exp_beats.size()) $display("FAIL rand_nbeats: got %0d want %0d", got_beats.size(), exp_beats.size());
      else n_pass++;
      for (int i = 0; i < exp_beats.size() && i < got_beats.size(); i++) begin
         n_total++;
         if (got_beats[i].d !== exp_beats[i].d || got_beats[i].l !== exp_beats[i].l || got_beats[i].u !== exp_beats[i].u)
            $display("FAIL rand_beat%0d: got d=%h l=%b want d=%h l=%b", i,
                     got_beats[i].d, got_beats[i].l, exp_beats[i].d, exp_beats[i].l);
         else n_pass++;
      end
      for (int k = 0; k < 6; k++) begin
         rb_read(8'(k), v);
         n_total++;
         if (v !== model_stat(k)) $display("FAIL rand_rb%0d: got %h want %h", k, v, model_stat(k));
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_packet();
      logic [63:0] v;
      reset_queues();
      tr_mode = 2;
      @(posedge clk); #2;
      send_beat($urandom, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 64'd0, 1'b0, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL midrst_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
      n_total++; if (s_axis_tready !== 1'b1) $display("FAIL midrst_tready: got %b want 1", s_axis_tready); else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      tr_mode = 0;
      reset_queues();
      model_clear();
      m_last = 32'h0;
      @(posedge clk); #2;
      send_packet(2, 32'd10, 1'b1, 64'd17, 1'b0);
      drain();
      n_total++;
      if (got_lat.size() != 1 || latency_out !== 32'd7)
         $display("FAIL midrst_lat: got %0d samples last=%0d want 1 sample of 7", got_lat.size(), latency_out);
      else n_pass++;
      rb_read(8'd0, v);
      n_total++; if (v !== 64'd1) $display("FAIL midrst_count: got %0d want 1", v); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap();
      test_three();
      test_backpressure();
      test_no_time();
      test_clear();
      test_random();
      test_reset_mid_packet();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
